// File: rtl/dcomp_gain_ctrl.sv
// Gain controller for the dcompressor datapath: peak envelope follower with
// separate attack/release rates feeding a threshold/ratio gain computed by a serial divider.
module dcomp_gain_ctrl #(
    parameter int unsigned ATTACK_SHIFT  = 2,
    parameter int unsigned RELEASE_SHIFT = 6
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_sample,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_threshold,
    input  logic [1:0] i_ratio_shift,
    output logic [7:0] o_gain,
    output logic       o_gain_valid,
    output logic [7:0] o_env
);

    typedef enum logic [1:0] {S_IDLE, S_ENV, S_DIV, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  abs_q, thr_q, env_hi_q, rem_q, quo_q;
    logic [1:0]  ratio_q;
    logic [15:0] env_q;
    logic        bypass_q;
    logic [3:0]  cnt_q;

    logic [7:0]  sample_abs;
    logic [15:0] level, env_nxt;
    logic [7:0]  env_hi_nxt, excess, target;
    logic        bypass_nxt;
    logic [8:0]  rem_sh;
    logic        rem_ge;
    logic [7:0]  rem_sub;

    // Magnitude of the signed sample; -128 saturates to 127 so env stays below 0x7F00.
    always_comb begin
        sample_abs = i_sample;
        if (i_sample[7]) begin
            sample_abs = (i_sample == 8'h80) ? 8'h7F : (~i_sample + 8'd1);
        end
    end

    always_comb begin
        level = {abs_q, 8'h00};
        if (level > env_q) begin
            env_nxt = env_q + ((level - env_q) >> ATTACK_SHIFT);
        end else begin
            env_nxt = env_q - ((env_q - level) >> RELEASE_SHIFT);
        end
        env_hi_nxt = env_nxt[15:8];
        bypass_nxt = (env_hi_nxt <= thr_q);
        excess     = env_hi_nxt - thr_q;
        target     = thr_q + (excess >> ratio_q);
    end

    // Restoring step: remainder stays below the divisor, so 8 bits plus the shifted-out MSB suffice.
    always_comb begin
        rem_sh  = {rem_q, 1'b0};
        rem_ge  = (rem_sh >= {1'b0, env_hi_q});
        rem_sub = rem_sh[7:0] - env_hi_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = S_ENV;
                end
            end
            S_ENV:  state_nxt = S_DIV;
            S_DIV: begin
                if (cnt_q == 4'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            abs_q        <= '0;
            thr_q        <= '0;
            ratio_q      <= '0;
            env_q        <= '0;
            env_hi_q     <= '0;
            bypass_q     <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            o_gain       <= '1;
            o_gain_valid <= 1'b0;
            o_env        <= '0;
        end else begin
            o_gain_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        abs_q   <= sample_abs;
                        thr_q   <= i_threshold;
                        ratio_q <= i_ratio_shift;
                    end
                end
                S_ENV: begin
                    env_q    <= env_nxt;
                    env_hi_q <= env_hi_nxt;
                    bypass_q <= bypass_nxt;
                    rem_q    <= bypass_nxt ? '0 : target;
                    quo_q    <= '0;
                    cnt_q    <= '0;
                end
                S_DIV: begin
                    rem_q <= rem_ge ? rem_sub : rem_sh[7:0];
                    quo_q <= {quo_q[6:0], rem_ge};
                    cnt_q <= cnt_q + 4'd1;
                end
                S_DONE: begin
                    o_gain       <= bypass_q ? 8'hFF : quo_q;
                    o_gain_valid <= 1'b1;
                    o_env        <= env_hi_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcomp_gain_ctrl.sv
// Self-checking bench for dcomp_gain_ctrl: directed table, busy/reset sequences
// and a randomized run against an arithmetic model of envelope and gain.
module tb_dcomp_gain_ctrl;

    localparam int unsigned ATTACK  = 2;
    localparam int unsigned RELEASE = 6;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_sample;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_threshold;
    logic [1:0] i_ratio_shift;
    logic [7:0] o_gain;
    logic       o_gain_valid;
    logic [7:0] o_env;

    dcomp_gain_ctrl #(
        .ATTACK_SHIFT (ATTACK),
        .RELEASE_SHIFT(RELEASE)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_sample     (i_sample),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_threshold  (i_threshold),
        .i_ratio_shift(i_ratio_shift),
        .o_gain       (o_gain),
        .o_gain_valid (o_gain_valid),
        .o_env        (o_env)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned m_env = 0;

    typedef struct {
        logic [7:0]  s;
        logic [7:0]  thr;
        logic [1:0]  r;
        int unsigned reps;
        int unsigned gain;
        int unsigned env;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Envelope in Q8.8 as a plain integer; gain = target/env_hi as Q0.8, clipped at unity.
    function automatic void model(input logic [7:0] s, input logic [7:0] thr, input logic [1:0] r,
                                  output int unsigned g, output int unsigned e);
        int          v;
        int unsigned mag, a, tgt, t;
        v   = int'($signed(s));
        mag = (v < 0) ? int'(-v) : v;
        if (mag > 127) mag = 127;
        a = mag * 256;
        if (a > m_env) m_env = m_env + ((a - m_env) >> ATTACK);
        else           m_env = m_env - ((m_env - a) >> RELEASE);
        e = m_env / 256;
        t = thr;
        if (e <= t) begin
            g = 255;
        end else begin
            tgt = t + ((e - t) >> r);
            g   = (tgt * 256) / e;
            if (g > 255) g = 255;
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input string name, input logic [7:0] s, input logic [7:0] thr,
                        input logic [1:0] r, output int unsigned ag, output int unsigned ae);
        int unsigned eg, ee, n;
        ag = 0;
        ae = 0;
        n  = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        if (!o_ready) begin
            check({name, "_ready_timeout"}, 0, 1);
            return;
        end
        i_sample      = s;
        i_threshold   = thr;
        i_ratio_shift = r;
        i_valid       = 1'b1;
        tick();
        i_valid = 1'b0;
        model(s, thr, r, eg, ee);
        n = 0;
        while (!o_gain_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 10);
        ag = o_gain;
        ae = o_env;
        check({name, "_gain"}, ag, eg);
        check({name, "_env"}, ae, ee);
        tick();
        check({name, "_strobe_len"}, o_gain_valid, 0);
    endtask

    initial begin
        int unsigned g, e, accepts, strobes, eg, ee, n;
        int unsigned qg[$];
        int unsigned qe[$];
        logic        acc;

        tbl[0] = '{8'd0,   8'd64,  2'd0, 1,  255, 0};    // zero sample bypasses
        tbl[1] = '{8'd100, 8'd64,  2'd1, 64, 209, 99};   // settle at +100, 2:1
        tbl[2] = '{8'd0,   8'd64,  2'd1, 1,  211, 98};   // one release step
        tbl[3] = '{8'h80,  8'd127, 2'd0, 64, 255, 126};  // -128 saturates, below knee

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_sample = '0;
        i_threshold = '0;
        i_ratio_shift = '0;
        repeat (3) tick();
        i_reset = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_gain", o_gain, 255);
        check("rst_strobe", o_gain_valid, 0);
        check("rst_env", o_env, 0);

        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned k = 0; k < tbl[i].reps; k++) begin
                send($sformatf("tbl%0d", i), tbl[i].s, tbl[i].thr, tbl[i].r, g, e);
            end
            check($sformatf("tbl%0d_final_gain", i), g, tbl[i].gain);
            check($sformatf("tbl%0d_final_env", i), e, tbl[i].env);
        end

        // i_valid held high with new data every cycle; only idle-cycle samples count
        accepts = 0;
        strobes = 0;
        i_valid = 1'b1;
        for (int unsigned c = 0; c < 60; c++) begin
            i_sample      = 8'($urandom_range(0, 255));
            i_threshold   = 8'($urandom_range(0, 100));
            i_ratio_shift = 2'($urandom_range(0, 3));
            acc = o_ready;
            if (acc) begin
                model(i_sample, i_threshold, i_ratio_shift, eg, ee);
                qg.push_back(eg);
                qe.push_back(ee);
                accepts++;
            end
            tick();
            if (o_gain_valid) begin
                strobes++;
                if (qg.size() == 0) begin
                    check("busy_unexpected_strobe", 1, 0);
                end else begin
                    check("busy_gain", o_gain, qg.pop_front());
                    check("busy_env", o_env, qe.pop_front());
                end
            end
        end
        i_valid = 1'b0;
        for (int unsigned c = 0; c < 12; c++) begin
            tick();
            if (o_gain_valid) begin
                strobes++;
                if (qg.size() == 0) begin
                    check("drain_unexpected_strobe", 1, 0);
                end else begin
                    check("drain_gain", o_gain, qg.pop_front());
                    check("drain_env", o_env, qe.pop_front());
                end
            end
        end
        check("busy_accepts", accepts, 6);
        check("busy_strobes", strobes, 6);
        check("busy_queue_empty", qg.size(), 0);

        // leave a non-unity gain so the reset check below is meaningful
        send("pre_reset", 8'd127, 8'd0, 2'd2, g, e);

        i_sample = 8'd100;
        i_threshold = 8'd10;
        i_ratio_shift = 2'd1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (4) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        m_env = 0;
        check("abort_ready", o_ready, 1);
        check("abort_gain", o_gain, 255);
        check("abort_strobe", o_gain_valid, 0);
        check("abort_env", o_env, 0);
        n = 0;
        for (int unsigned c = 0; c < 15; c++) begin
            tick();
            if (o_gain_valid) n++;
        end
        check("abort_no_strobe", n, 0);
        send("post_reset", 8'd100, 8'd0, 2'd1, g, e);
        check("post_reset_gain_const", g, 122);
        check("post_reset_env_const", e, 25);

        for (int unsigned i = 0; i < 2000; i++) begin
            send($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), g, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
